// File: rtl/obstacle_pkg.sv
// rtl/obstacle_pkg.sv - shared obstacle colour type, mode encodings and default palette
package obstacle_pkg;

   typedef logic [11:0] rgb12;

   typedef enum logic [1:0] {
      MODE_FLAT   = 2'd0,
      MODE_HILITE = 2'd1,
      MODE_BLANK  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   localparam rgb12 DEF_MORTAR_COLOR = 12'hFFF;
   localparam rgb12 DEF_BRICK_COLOR  = 12'h000;
   localparam rgb12 DEF_HILITE_COLOR = 12'h444;
   localparam rgb12 BLANK_COLOR      = 12'h000;

endpackage

// File: rtl/brick_pattern_eval.sv
// rtl/brick_pattern_eval.sv - combinational brick geometry: (row, scrolled col, mode) -> colour
module brick_pattern_eval
   import obstacle_pkg::*;
#(
   parameter int   TILE_W       = 32,
   parameter int   BRICK_W      = 10,
   parameter int   BRICK_H      = 6,
   parameter rgb12 MORTAR_COLOR = DEF_MORTAR_COLOR,
   parameter rgb12 BRICK_COLOR  = DEF_BRICK_COLOR,
   parameter rgb12 HILITE_COLOR = DEF_HILITE_COLOR
) (
   input  logic [$clog2(TILE_W)-1:0] row,
   input  logic [$clog2(TILE_W)-1:0] cs,
   input  logic [1:0]                mode,
   input  logic                      oor,
   output logic [11:0]               color
);

   localparam int AW = $clog2(TILE_W);
   // One extra bit so BRICK_x == TILE_W (a power of two) still fits as a divisor
   localparam int XW = AW + 1;

   logic [XW-1:0] course;
   logic [XW-1:0] rr;
   logic [XW-1:0] cc;
   logic          course_odd;
   logic          mortar;
   logic          blank;

   always_comb begin
      course     = {1'b0, row} / XW'(BRICK_H);
      rr         = {1'b0, row} % XW'(BRICK_H);
      course_odd = (course & XW'(1)) != '0;
      cc         = ({1'b0, cs} + (course_odd ? XW'(BRICK_W / 2) : '0)) % XW'(BRICK_W);
      mortar     = (rr == XW'(BRICK_H - 1)) || (cc == XW'(BRICK_W - 1));
      blank      = oor || (mode == MODE_BLANK) || (mode == MODE_RSVD);

      color = BRICK_COLOR;
      if (blank) begin
         color = BLANK_COLOR;
      end else if (mortar) begin
         color = MORTAR_COLOR;
      end else if ((mode == MODE_HILITE) && (rr == '0)) begin
         color = HILITE_COLOR;
      end
   end

endmodule

// File: rtl/brick_tile_gen.sv
// rtl/brick_tile_gen.sv - two-stage brick texture pipeline with per-frame scroll and mode
module brick_tile_gen
   import obstacle_pkg::*;
#(
   parameter int   TILE_W       = 32,
   parameter int   BRICK_W      = 10,
   parameter int   BRICK_H      = 6,
   parameter rgb12 MORTAR_COLOR = DEF_MORTAR_COLOR,
   parameter rgb12 BRICK_COLOR  = DEF_BRICK_COLOR,
   parameter rgb12 HILITE_COLOR = DEF_HILITE_COLOR
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      pix_valid,
   input  logic [$clog2(TILE_W)-1:0] row,
   input  logic [$clog2(TILE_W)-1:0] col,
   input  logic                      frame_tick,
   input  logic [$clog2(TILE_W)-1:0] scroll_step,
   input  logic [1:0]                mode_req,
   output logic [11:0]               color_data,
   output logic                      color_valid
);

   localparam int AW = $clog2(TILE_W);

   // Single conditional subtract is enough since both operands are below TILE_W
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
      logic [AW:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= (AW+1)'(TILE_W)) begin
         sum = sum - (AW+1)'(TILE_W);
      end
      return sum[AW-1:0];
   endfunction

   logic [AW-1:0] scroll;
   logic [1:0]    mode;

   logic          s1_valid;
   logic [AW-1:0] s1_row;
   logic [AW-1:0] s1_cs;
   logic          s1_oor;
   logic [1:0]    s1_mode;

   rgb12          pixel;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scroll <= '0;
         mode   <= MODE_FLAT;
      end else if (frame_tick) begin
         scroll <= wrap_add(scroll, scroll_step);
         mode   <= mode_req;
      end
   end

   // Stage 1 samples the pre-tick scroll/mode, so a coincident tick lands on the next pixel
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_row   <= '0;
         s1_cs    <= '0;
         s1_oor   <= 1'b0;
         s1_mode  <= MODE_FLAT;
      end else begin
         s1_valid <= pix_valid;
         if (pix_valid) begin
            s1_row  <= row;
            s1_cs   <= wrap_add(col, scroll);
            s1_oor  <= ({1'b0, row} >= (AW+1)'(TILE_W)) || ({1'b0, col} >= (AW+1)'(TILE_W));
            s1_mode <= mode;
         end
      end
   end

   brick_pattern_eval #(
      .TILE_W       (TILE_W),
      .BRICK_W      (BRICK_W),
      .BRICK_H      (BRICK_H),
      .MORTAR_COLOR (MORTAR_COLOR),
      .BRICK_COLOR  (BRICK_COLOR),
      .HILITE_COLOR (HILITE_COLOR)
   ) u_eval (
      .row   (s1_row),
      .cs    (s1_cs),
      .mode  (s1_mode),
      .oor   (s1_oor),
      .color (pixel)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         color_valid <= 1'b0;
         color_data  <= 12'h000;
      end else begin
         color_valid <= s1_valid;
         if (s1_valid) begin
            color_data <= pixel;
         end
      end
   end

endmodule
